// File: rtl/musa_pkg.sv
// ---------------------------------------------------------------------------
// musa_pkg -- constants and types shared by the return-address stack.
//
// Contents:
//   DEFAULT_ADDR_W : default return-address width (bits)
//   RSTACK_DEPTH   : default number of return-address entries
//   rstack_op_e    : the single operation the stack performs in a cycle
// ---------------------------------------------------------------------------
package musa_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int RSTACK_DEPTH   = 8;

    // Exactly one of these is selected per cycle from the push/pop edges and
    // the current fill level; the state registers simply act on it.
    typedef enum logic [2:0] {
        OP_NONE,       // no edge, nothing to do
        OP_PUSH,       // store a new top, count + 1
        OP_POP,        // discard the top, count - 1
        OP_REPLACE,    // push and pop together: overwrite top in place
        OP_OVERWRITE,  // push on full, oldest entry is lost
        OP_DROP,       // push on full, request discarded
        OP_UNDERRUN    // pop on empty
    } rstack_op_e;

endpackage

// File: rtl/return_stack_if.sv
// ---------------------------------------------------------------------------
// return_stack_if -- CALL/RET request and status bundle between the control
// unit (master) and the return-address stack (slave).
//
// Signals:
//   push      : CALL request level (master -> slave)
//   pop       : RET request level (master -> slave)
//   push_addr : return address to store (master -> slave)
//   top_addr  : current top-of-stack address, 0 when empty (slave -> master)
//   count     : number of valid entries (slave -> master)
//   empty     : count == 0
//   full      : count == DEPTH
//   overflow  : sticky, push attempted on full stack
//   underflow : sticky, pop attempted on empty stack
// ---------------------------------------------------------------------------
interface return_stack_if
    import musa_pkg::*;
#(
    parameter int DEPTH  = RSTACK_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) ();

    logic                         push;
    logic                         pop;
    logic [ADDR_W-1:0]            push_addr;
    logic [ADDR_W-1:0]            top_addr;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         empty;
    logic                         full;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output push, pop, push_addr,
        input  top_addr, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_addr,
        output top_addr, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/rstack_edge_det.sv
// ---------------------------------------------------------------------------
// rstack_edge_det -- rising-edge detector for a request level.
//
// Ports:
//   clk     : clock
//   reset   : synchronous active-high reset, clears the previous-level flop
//   i_level : request level
//   o_rise  : high for the one cycle in which i_level is high and was low
//             at the previous clock edge
// ---------------------------------------------------------------------------
module rstack_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    // Clearing r_prev on reset makes a level still held after reset look
    // like a fresh edge.
    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/return_stack.sv
// ---------------------------------------------------------------------------
// return_stack -- circular-buffer return-address stack for CALL/RET.
//
// Acts once per rising edge of the push/pop request levels. Storage is a
// DEPTH-entry circular buffer addressed by a top pointer that wraps modulo
// DEPTH.
//
// Parameters:
//   DEPTH  : number of entries (power of two, 2..64)
//   ADDR_W : return-address width
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : return_stack_if.slave (push/pop/push_addr in; top_addr, count,
//           empty, full, overflow, underflow out)
//
// Build option:
//   RSTACK_OVERWRITE_EN : when defined, a push on a full stack overwrites
//                         the oldest entry; otherwise the push is dropped.
//                         The overflow flag is set in both cases.
// ---------------------------------------------------------------------------
module return_stack
    import musa_pkg::*;
#(
    parameter int DEPTH  = RSTACK_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    return_stack_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic w_push_rise;
    logic w_pop_rise;

    rstack_edge_det u_push_edge (
        .clk     (clk),
        .reset   (reset),
        .i_level (bus.push),
        .o_rise  (w_push_rise)
    );

    rstack_edge_det u_pop_edge (
        .clk     (clk),
        .reset   (reset),
        .i_level (bus.pop),
        .o_rise  (w_pop_rise)
    );

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_top_ptr;   // index of the current top entry
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    rstack_op_e        w_op;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // Operation select. A simultaneous push/pop is a replace when there is
    // a top to replace, and a plain push when empty (no underflow).
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        w_op = OP_NONE;
        if (w_push_rise && w_pop_rise) begin
            w_op = w_empty ? OP_PUSH : OP_REPLACE;
        end else if (w_push_rise) begin
            if (!w_full) begin
                w_op = OP_PUSH;
            end else begin
`ifdef RSTACK_OVERWRITE_EN
                w_op = OP_OVERWRITE;
`else
                w_op = OP_DROP;
`endif
            end
        end else if (w_pop_rise) begin
            w_op = w_empty ? OP_UNDERRUN : OP_POP;
        end
    end

    // Pointer, count and sticky flags. Overwrite on full advances the
    // pointer onto the oldest slot while the count stays at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_top_ptr   <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (w_op)
                OP_PUSH: begin
                    r_top_ptr <= r_top_ptr + PTR_ONE;
                    r_count   <= r_count + CNT_W'(1);
                end
                OP_POP: begin
                    r_top_ptr <= r_top_ptr - PTR_ONE;
                    r_count   <= r_count - CNT_W'(1);
                end
                OP_OVERWRITE: begin
                    r_top_ptr  <= r_top_ptr + PTR_ONE;
                    r_overflow <= 1'b1;
                end
                OP_DROP:     r_overflow  <= 1'b1;
                OP_UNDERRUN: r_underflow <= 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the entry array has no reset; validity is tracked by r_count
    // and top_addr is forced to 0 when empty, so stale contents are never
    // visible. Writes are still suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            case (w_op)
                OP_PUSH, OP_OVERWRITE: r_mem[r_top_ptr + PTR_ONE] <= bus.push_addr;
                OP_REPLACE:            r_mem[r_top_ptr]           <= bus.push_addr;
                default: ;
            endcase
        end
    end

    assign bus.top_addr  = w_empty ? '0 : r_mem[r_top_ptr];
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule
